// File: rtl/psa_simd_pipe.sv
// psa_simd_pipe: two-stage pipelined partitioned (SIMD) signed adder/subtractor.
// A and B are split into LANES two's-complement lanes of LANE_W bits. No carry
// crosses a lane boundary. Each op selects add/sub and saturate/wrap.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   operand handshake (in_ready is combinational from out_ready)
//   op                  [0]=0 add, 1 sub (A-B); [1]=0 saturate, 1 wrap
//   A, B                lane-packed operands, lane i = X[i*LANE_W +: LANE_W]
//   out_valid/out_ready result handshake
//   Sum                 lane-packed result
//   ovf                 per-lane signed overflow of the raw (pre-saturation) result
//   err                 sticky OR of ovf for every result loaded into stage 2
//   clr_err             clears err (a simultaneous set wins)
module psa_simd_pipe #(
    parameter int unsigned LANE_W = 4,
    parameter int unsigned LANES  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [1:0]                op,
    input  logic [LANE_W*LANES-1:0]   A,
    input  logic [LANE_W*LANES-1:0]   B,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANE_W*LANES-1:0]   Sum,
    output logic [LANES-1:0]          ovf,
    output logic                      err,
    input  logic                      clr_err
);

    localparam int unsigned W   = LANE_W * LANES;
    localparam int unsigned MSB = LANE_W - 1;

    localparam logic [LANE_W-1:0] LANE_MIN = {1'b1, {(LANE_W-1){1'b0}}};
    localparam logic [LANE_W-1:0] LANE_MAX = {1'b0, {(LANE_W-1){1'b1}}};

    // Stage 1: registered operands
    logic           s1_valid;
    logic [W-1:0]   s1_a;
    logic [W-1:0]   s1_b;
    logic [1:0]     s1_op;

    logic           s1_en;
    logic           s2_en;

    logic [W-1:0]     lane_res;
    logic [LANES-1:0] lane_ovf;

    // Stage 2 (out_valid/Sum/ovf) moves when empty or being drained; stage 1
    // moves when empty or when stage 2 can take its contents.
    assign s2_en    = !out_valid || out_ready;
    assign s1_en    = !s1_valid || s2_en;
    assign in_ready = s1_en;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [LANE_W-1:0] a;
        logic [LANE_W-1:0] b;
        logic [LANE_W-1:0] b_eff;
        logic [LANE_W-1:0] r;
        logic              same_sign;
        logic              v;

        assign a     = s1_a[g*LANE_W +: LANE_W];
        assign b     = s1_b[g*LANE_W +: LANE_W];
        // Subtract as a + ~b + 1; the carry-in stays inside this lane.
        assign b_eff = s1_op[0] ? ~b : b;
        assign r     = a + b_eff + {{(LANE_W-1){1'b0}}, s1_op[0]};

        // Overflow when the effective operands share a sign and the result flips it.
        assign same_sign = s1_op[0] ? (a[MSB] != b[MSB]) : (a[MSB] == b[MSB]);
        assign v         = same_sign && (r[MSB] != a[MSB]);

        assign lane_ovf[g] = v;
        // On overflow the true result has a's sign: negative clamps to min, positive to max.
        assign lane_res[g*LANE_W +: LANE_W] =
            (v && !s1_op[1]) ? (a[MSB] ? LANE_MIN : LANE_MAX) : r;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_op     <= '0;
            out_valid <= 1'b0;
            Sum       <= '0;
            ovf       <= '0;
            err       <= 1'b0;
        end else begin
            if (s1_en) begin
                s1_valid <= in_valid;
                s1_a     <= A;
                s1_b     <= B;
                s1_op    <= op;
            end
            if (s2_en) begin
                out_valid <= s1_valid;
                // Bubbles leave the last result in place.
                if (s1_valid) begin
                    Sum <= lane_res;
                    ovf <= lane_ovf;
                end
            end
            err <= (err && !clr_err) || (s2_en && s1_valid && (|lane_ovf));
        end
    end

endmodule

// File: tb/tb_psa_simd_pipe.sv
// Bench for psa_simd_pipe: directed vectors with literal expectations plus a
// lane-arithmetic reference model and per-cycle compare of every output.
module tb_psa_simd_pipe;

    localparam int LW = 4;
    localparam int NL = 4;
    localparam int W  = LW * NL;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   op;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] Sum;
    logic [NL-1:0] ovf;
    logic         err;
    logic         clr_err;

    int total = 0;
    int bad   = 0;
    int n_out = 0;

    psa_simd_pipe #(
        .LANE_W (LW),
        .LANES  (NL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Sum       (Sum),
        .ovf       (ovf),
        .err       (err),
        .clr_err   (clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: signed integer lane arithmetic, then clamp or truncate.
    function automatic logic [NL+W-1:0] model(input logic [1:0] o, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        logic [W-1:0]  s;
        logic [NL-1:0] v;
        int x, y, r, mx, mn;
        mx = (1 << (LW - 1)) - 1;
        mn = -(1 << (LW - 1));
        for (int i = 0; i < NL; i++) begin
            x = int'(a[i*LW +: LW]);
            y = int'(b[i*LW +: LW]);
            if (x > mx) x -= (1 << LW);
            if (y > mx) y -= (1 << LW);
            r = o[0] ? x - y : x + y;
            v[i] = (r > mx) || (r < mn);
            if (v[i] && !o[1]) r = (r > mx) ? mx : mn;
            s[i*LW +: LW] = LW'(r);
        end
        return {v, s};
    endfunction

    // Scoreboard of accepted-but-not-delivered results.
    logic [NL+W-1:0] q[$];
    logic shown    = 1'b0;
    logic exp_err  = 1'b0;
    logic rst_prev = 1'b0;
    logic clr_prev = 1'b0;

    always @(negedge clk) begin
        logic [NL+W-1:0] f;
        if (!rst_prev) begin
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_sum", 32'(Sum), 32'd0);
            check("rst_ovf", 32'(ovf), 32'd0);
            exp_err = 1'b0;
        end else begin
            exp_err = exp_err && !clr_prev;
            if (q.size() == 0) begin
                check("idle_out_valid", 32'(out_valid), 32'd0);
            end else if (out_valid) begin
                f = q[0];
                check("sum", 32'(Sum), 32'(f[W-1:0]));
                check("ovf", 32'(ovf), 32'(f[W +: NL]));
                if (!shown) begin
                    shown = 1'b1;
                    if (f[W +: NL] != '0) exp_err = 1'b1;
                end
            end
        end
        check("err", 32'(err), 32'(exp_err));
        check("in_ready", 32'(in_ready), 32'(out_ready || (q.size() < 2)));
        rst_prev = rst_n;
        clr_prev = clr_err;
        if (!rst_n) begin
            q.delete();
            shown = 1'b0;
        end else begin
            if (out_valid && out_ready && q.size() > 0) begin
                void'(q.pop_front());
                shown = 1'b0;
                n_out++;
            end
            if (in_valid && in_ready) q.push_back(model(op, A, B));
        end
    end

    // Inputs change just after the rising edge; checks look just after the falling edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic look;
        @(negedge clk);
        #1;
    endtask

    task automatic push_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        logic acc;
        int n;
        acc = 1'b0;
        n = 0;
        in_valid = 1'b1;
        op = o;
        A = a;
        B = b;
        while (!acc && n < 50) begin
            look;
            acc = in_ready;
            tick;
            n++;
        end
        check("push_accept", 32'(acc), 32'd1);
        in_valid = 1'b0;
    endtask

    function automatic logic [W-1:0] item_a(input int k);
        return 16'h1357 + W'(k) * 16'h2222;
    endfunction

    function automatic logic [W-1:0] item_b(input int k);
        return 16'h0F1E ^ (W'(k) * 16'h1111);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int j;
        logic a_rdy;

        rst_n = 1'b0;
        in_valid = 1'b0;
        op = 2'b00;
        A = '0;
        B = '0;
        out_ready = 1'b1;
        clr_err = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        look;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        check("reset_sum", 32'(Sum), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);

        // 1: add saturate, two-edge latency
        tick;
        in_valid = 1'b1; op = 2'b00; A = 16'h7831; B = 16'h1F21;
        tick;
        in_valid = 1'b0;
        look;
        check("t1_not_yet", 32'(out_valid), 32'd0);
        tick;
        look;
        check("t1_valid", 32'(out_valid), 32'd1);
        check("t1_sum", 32'(Sum), 32'h7852);
        check("t1_ovf", 32'(ovf), 32'hC);
        check("t1_err", 32'(err), 32'd1);

        // 2: sub saturate then sub wrap, back to back
        tick;
        in_valid = 1'b1; op = 2'b01; A = 16'h8705; B = 16'h1F15;
        tick;
        op = 2'b11;
        tick;
        in_valid = 1'b0;
        look;
        check("t2_sat_sum", 32'(Sum), 32'h87F0);
        check("t2_sat_ovf", 32'(ovf), 32'hC);
        tick;
        look;
        check("t2_wrap_sum", 32'(Sum), 32'h78F0);
        check("t2_wrap_ovf", 32'(ovf), 32'hC);

        // 3: eight ops streamed with out_ready held high
        tick;
        n0 = n_out;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            op = 2'(i);
            A = item_a(i);
            B = item_b(i);
            check("t3_in_ready", 32'(in_ready), 32'd1);
            tick;
        end
        in_valid = 1'b0;
        look;
        check("t3_count7", 32'(n_out - n0), 32'd7);
        tick;
        look;
        check("t3_count8", 32'(n_out - n0), 32'd8);

        // 4: consumer stalls for five cycles while the producer keeps offering
        tick;
        n0 = n_out;
        out_ready = 1'b0;
        j = 0;
        in_valid = 1'b1; op = 2'(j); A = item_a(j + 3); B = item_b(j + 5);
        for (int c = 0; c < 5; c++) begin
            look;
            a_rdy = in_ready;
            tick;
            if (a_rdy) begin
                j++;
                op = 2'(j); A = item_a(j + 3); B = item_b(j + 5);
            end
        end
        check("t4_accepts", 32'(j), 32'd2);
        look;
        check("t4_in_ready_low", 32'(in_ready), 32'd0);
        check("t4_held_valid", 32'(out_valid), 32'd1);
        tick;
        out_ready = 1'b1;
        for (int k = j; k < 6; k++) push_op(2'(k), item_a(k + 3), item_b(k + 5));
        repeat (4) tick;
        look;
        check("t4_delivered", 32'(n_out - n0), 32'd6);

        // 5: sticky err, then clear colliding with an overflowing load
        tick;
        push_op(2'b00, 16'h1111, 16'h1111);
        repeat (3) tick;
        look;
        check("t5_sticky", 32'(err), 32'd1);
        tick;
        in_valid = 1'b1; op = 2'b00; A = 16'h7000; B = 16'h1000;
        tick;
        in_valid = 1'b0;
        clr_err = 1'b1;
        tick;
        clr_err = 1'b0;
        look;
        check("t5_set_wins", 32'(err), 32'd1);
        tick;
        clr_err = 1'b1;
        tick;
        clr_err = 1'b0;
        look;
        check("t5_cleared", 32'(err), 32'd0);

        // 6: reset with two ops in flight
        tick;
        out_ready = 1'b0;
        push_op(2'b00, 16'h7000, 16'h1000);
        push_op(2'b01, 16'h0123, 16'h0011);
        look;
        check("t6_pre_err", 32'(err), 32'd1);
        tick;
        rst_n = 1'b0;
        out_ready = 1'b1;
        tick;
        rst_n = 1'b1;
        look;
        check("t6_out_valid", 32'(out_valid), 32'd0);
        check("t6_err", 32'(err), 32'd0);
        check("t6_sum", 32'(Sum), 32'd0);
        check("t6_in_ready", 32'(in_ready), 32'd1);

        // Recovery after reset: sub of min-min is zero with no overflow
        tick;
        n0 = n_out;
        push_op(2'b01, 16'h8888, 16'h8888);
        tick;
        look;
        check("t6_minmin_sum", 32'(Sum), 32'h0000);
        check("t6_minmin_ovf", 32'(ovf), 32'h0);
        tick;
        look;
        check("t6_recovered", 32'(n_out - n0), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
